// File: rtl/result_display_sequencer.sv
// -----------------------------------------------------------------------------
// result_display_sequencer
//
// Buffers a burst of result bytes from the systolic-array output stage and
// shows them one at a time on the 4-digit seven-segment driver. Each value is
// held for DWELL_CYCLES clocks. After that the next buffered value appears with
// no gap cycle. When the buffer runs dry, the last value stays on the display
// (HOLD) until new data arrives.
//
// Optional feature (compile-time macro DISPLAY_INDEX_EN):
//   When defined, a 3-bit burst position index is added in the thousands digit
//   (displayed = index*1000 + value). When undefined, displayed is the
//   zero-extended value.
//
// Ports:
//   clock_100Mhz  in   system clock
//   reset         in   asynchronous, active-high reset
//   in_valid      in   producer offers in_data this cycle
//   in_data       in   result byte (DATA_W bits)
//   in_ready      out  buffer can accept a byte this cycle (not full)
//   clear         in   synchronous flush: empty buffer, blank display, IDLE
//   displayed     out  16-bit value for the segment driver (0..9999)
//   show_valid    out  displayed holds a real result
//   busy          out  dwell in progress or buffer non-empty
//   level         out  buffer occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module result_display_sequencer #(
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int DATA_W       = 8
) (
    input  logic                     clock_100Mhz,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     clear,
    output logic [15:0]              displayed,
    output logic                     show_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DWELL_CYCLES);
    localparam int RELOAD_INT = DWELL_CYCLES - 1;

    localparam logic [CNT_W-1:0] DWELL_RELOAD = RELOAD_INT[CNT_W-1:0];
    localparam logic [PTR_W:0]   FULL_LEVEL   = DEPTH[PTR_W:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [1:0]        state;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [15:0]       disp_reg;
    logic [15:0]       shown_value;
    logic              do_push;
    logic              do_pop;

    // A full buffer refuses the push even when a pop happens in the same
    // cycle. This keeps in_ready a pure function of the stored count.
    assign in_ready   = (count != FULL_LEVEL);
    assign do_push    = in_valid && in_ready && !clear;
    assign level      = count;
    assign displayed  = disp_reg;
    assign show_valid = (state != IDLE);
    assign busy       = (state == SHOW) || (count != '0);

    // NOTE: every variable in a combinational block gets a default first,
    // so that no path leaves it unassigned and infers a latch.
    always_comb begin
        do_pop = 1'b0;
        if (!clear && count != '0) begin
            case (state)
                IDLE:    do_pop = 1'b1;
                SHOW:    do_pop = (dwell_cnt == '0);
                HOLD:    do_pop = 1'b1;
                default: do_pop = 1'b0;
            endcase
        end
    end

`ifdef DISPLAY_INDEX_EN
    // Position of the next popped entry in the current burst. It wraps after 7.
    // IDLE is entered only through reset or clear, and both zero the index.
    logic [2:0] seq_idx;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            seq_idx <= '0;
        end else if (clear) begin
            seq_idx <= '0;
        end else if (do_pop) begin
            seq_idx <= seq_idx + 1'b1;
        end
    end

    // Constant-by-3-bit product: the index lands in the thousands digit.
    assign shown_value = 16'(mem[rd_ptr]) + 16'(seq_idx) * 16'd1000;
`else
    assign shown_value = 16'(mem[rd_ptr]);
`endif

    // NOTE: the storage array has no reset. Pointers and count define which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge clock_100Mhz) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together on the edge, whatever the statement order.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            dwell_cnt <= '0;
            disp_reg  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            dwell_cnt <= '0;
            disp_reg  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: if (do_pop) state <= SHOW;
                SHOW: begin
                    if (dwell_cnt == '0) begin
                        if (!do_pop) state <= HOLD;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                HOLD: if (do_pop) state <= SHOW;
                default: state <= IDLE;
            endcase

            // A pop always starts a fresh dwell. This reload overrides the
            // decrement above.
            if (do_pop) begin
                disp_reg  <= shown_value;
                dwell_cnt <= DWELL_RELOAD;
            end
        end
    end

endmodule
